// File: rtl/nco_clk_pkg.sv
// Shared constants, helper functions and types for the multi-channel NCO clock generator.
package nco_clk_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift toggle mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        NCO_IDLE = 2'd0,
        NCO_RUN  = 2'd1,
        NCO_SYNC = 2'd2
    } t_nco_state;

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [15:0] f_rotl16(input logic [15:0] s, input int k);
        logic [31:0] w_dbl;
        w_dbl = {s, s} << (k % 16);
        return w_dbl[31:16];
    endfunction

    // base + clamp(trim, +-limit), then clamp to [1, 2^(w-1)] so the NCO never stops or aliases
    function automatic logic [63:0] f_sat_step(input logic [63:0]        base,
                                               input logic signed [63:0] trim,
                                               input int                 limit,
                                               input int                 w);
        logic signed [63:0] lim;
        logic signed [63:0] hi;
        logic signed [63:0] t;
        logic signed [63:0] s;
        lim = 64'(limit);
        hi  = 64'sd1 <<< (w - 1);
        t   = trim;
        if (t > lim)
            t = lim;
        else if (t < -lim)
            t = -lim;
        s = $signed(base) + t;
        if (s < 64'sd1)
            s = 64'sd1;
        else if (s > hi)
            s = hi;
        return $unsigned(s);
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator NCO channel with trim shadow/pending logic and step clamp.
//   state    | meaning
//   NCO_IDLE | channel disabled: acc held at 0, clk high, no wrap
//   NCO_RUN  | add step + dither every cycle, apply pending trim on carry
//   NCO_SYNC | re-phase: acc forced to 0, add and wrap suppressed
module nco_channel
    import nco_clk_pkg::*;
#(
    parameter int                     g_acc_width  = 32,
    parameter int                     g_tune_width = 16,
    parameter logic [g_acc_width-1:0] g_base_step  = 32'h0800_0000,
    parameter int                     g_tune_limit = 1000
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    sync_i,
    input  logic [g_tune_width-1:0] tune_i,
    input  logic                    tune_stb_i,
    input  logic [g_acc_width-1:0]  dither_i,
    output logic                    tune_pending_o,
    output logic                    clk_o,
    output logic                    wrap_o,
    output logic [g_acc_width-1:0]  step_o
);

    localparam int W = g_acc_width;
    localparam int T = g_tune_width;

    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_step;
    logic [T-1:0]       r_shadow;
    logic               r_pending;
    logic               r_clk;
    logic               r_wrap;

    t_nco_state         w_state;
    logic [W:0]         w_sum;
    logic               w_carry;
    logic signed [63:0] w_trim_ext;
    logic [W-1:0]       w_step_new;

    always_comb begin
        w_state = NCO_RUN;
        if (!enable_i)
            w_state = NCO_IDLE;
        else if (sync_i)
            w_state = NCO_SYNC;
    end

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_step} + {1'b0, dither_i};
    assign w_carry    = w_sum[W];
    assign w_trim_ext = {{(64-T){r_shadow[T-1]}}, r_shadow};
    assign w_step_new = W'(f_sat_step(64'(g_base_step), w_trim_ext, g_tune_limit, W));

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc     <= '0;
            r_step    <= g_base_step;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_clk     <= 1'b1;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (w_state)
                NCO_IDLE, NCO_SYNC: begin
                    r_acc <= '0;
                    r_clk <= 1'b1;
                end
                default: begin
                    r_acc  <= w_sum[W-1:0];
                    r_clk  <= ~w_sum[W-1];
                    r_wrap <= w_carry;
                    if (w_carry && r_pending) begin
                        r_step    <= w_step_new;
                        r_pending <= 1'b0;
                    end
                end
            endcase
            // A strobe coinciding with an apply refills the shadow and keeps pending set
            if (tune_stb_i) begin
                r_shadow  <= tune_i;
                r_pending <= 1'b1;
            end
        end
    end

    assign tune_pending_o = r_pending;
    assign clk_o          = r_clk;
    assign wrap_o         = r_wrap;
    assign step_o         = r_step;

endmodule

// File: rtl/nco_multi_clock_gen.sv
// Multi-channel NCO clock generator: shared dither LFSR, sync fan-out and per-channel NCOs.
module nco_multi_clock_gen
    import nco_clk_pkg::*;
#(
    parameter int                     g_num_channels = 4,
    parameter int                     g_acc_width    = 32,
    parameter int                     g_tune_width   = 16,
    parameter logic [g_acc_width-1:0] g_base_step    = 32'h0800_0000,
    parameter int                     g_tune_limit   = 1000,
    parameter int                     g_dither_bits  = 0
) (
    input  logic                                   clk_sys_i,
    input  logic                                   rst_n_i,
    input  logic [g_num_channels-1:0]              enable_i,
    input  logic                                   sync_i,
    input  logic [g_num_channels*g_tune_width-1:0] tune_i,
    input  logic [g_num_channels-1:0]              tune_stb_i,
    output logic [g_num_channels-1:0]              tune_pending_o,
    output logic [g_num_channels-1:0]              clk_o,
    output logic [g_num_channels-1:0]              wrap_o,
    output logic [g_num_channels*g_acc_width-1:0]  step_o
);

    localparam int N      = g_num_channels;
    localparam int W      = g_acc_width;
    localparam int T      = g_tune_width;
    localparam int DW_RAW = (g_dither_bits > 16) ? 16 : g_dither_bits;
    // Dither kept below 2^(W-1) so acc + step + dither carries at most once
    localparam int DW     = (DW_RAW < W - 1) ? DW_RAW : W - 1;

    logic [N-1:0][W-1:0] w_dither;

    generate
        if (DW > 0) begin : g_lfsr
            localparam logic [15:0] DMASK = 16'((32'd1 << DW) - 32'd1);
            logic [15:0] r_lfsr;

            always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    r_lfsr <= LFSR_SEED;
                else
                    r_lfsr <= f_lfsr_next(r_lfsr);
            end

            for (genvar k = 0; k < N; k++) begin : g_rot
                assign w_dither[k] = W'(f_rotl16(r_lfsr, k) & DMASK);
            end
        end else begin : g_no_lfsr
            assign w_dither = '0;
        end
    endgenerate

    for (genvar k = 0; k < N; k++) begin : g_ch
        nco_channel #(
            .g_acc_width  (W),
            .g_tune_width (T),
            .g_base_step  (g_base_step),
            .g_tune_limit (g_tune_limit)
        ) u_ch (
            .clk_sys_i      (clk_sys_i),
            .rst_n_i        (rst_n_i),
            .enable_i       (enable_i[k]),
            .sync_i         (sync_i),
            .tune_i         (tune_i[k*T +: T]),
            .tune_stb_i     (tune_stb_i[k]),
            .dither_i       (w_dither[k]),
            .tune_pending_o (tune_pending_o[k]),
            .clk_o          (clk_o[k]),
            .wrap_o         (wrap_o[k]),
            .step_o         (step_o[k*W +: W])
        );
    end

endmodule

// File: tb/tb_nco_multi_clock_gen.sv
// Directed self-checking bench for nco_multi_clock_gen using four parameterisations.
module tb_nco_multi_clock_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A: W=8 base=16, trims and sync
    logic        rst_a, sync_a;
    logic [1:0]  en_a, stb_a, pend_a, clk_a, wrap_a;
    logic [15:0] tune_a, step_a;

    nco_multi_clock_gen #(
        .g_num_channels(2), .g_acc_width(8), .g_tune_width(8),
        .g_base_step(8'd16), .g_tune_limit(120), .g_dither_bits(0)
    ) u_dut_a (
        .clk_sys_i(clk), .rst_n_i(rst_a), .enable_i(en_a), .sync_i(sync_a),
        .tune_i(tune_a), .tune_stb_i(stb_a), .tune_pending_o(pend_a),
        .clk_o(clk_a), .wrap_o(wrap_a), .step_o(step_a)
    );

    // B and C: W=16 base=1500, limit 1000 and 2047
    logic        en_b, stb_b, pend_b, clk_b, wrap_b;
    logic        en_c, stb_c, pend_c, clk_c, wrap_c;
    logic [11:0] tune_b, tune_c;
    logic [15:0] step_b, step_c;
    logic        sync_0 = 1'b0;

    nco_multi_clock_gen #(
        .g_num_channels(1), .g_acc_width(16), .g_tune_width(12),
        .g_base_step(16'd1500), .g_tune_limit(1000), .g_dither_bits(0)
    ) u_dut_b (
        .clk_sys_i(clk), .rst_n_i(rst_a), .enable_i(en_b), .sync_i(sync_0),
        .tune_i(tune_b), .tune_stb_i(stb_b), .tune_pending_o(pend_b),
        .clk_o(clk_b), .wrap_o(wrap_b), .step_o(step_b)
    );

    nco_multi_clock_gen #(
        .g_num_channels(1), .g_acc_width(16), .g_tune_width(12),
        .g_base_step(16'd1500), .g_tune_limit(2047), .g_dither_bits(0)
    ) u_dut_c (
        .clk_sys_i(clk), .rst_n_i(rst_a), .enable_i(en_c), .sync_i(sync_0),
        .tune_i(tune_c), .tune_stb_i(stb_c), .tune_pending_o(pend_c),
        .clk_o(clk_c), .wrap_o(wrap_c), .step_o(step_c)
    );

    // D: W=16 base=4096 with 4 dither bits
    logic        rst_d;
    logic [1:0]  en_d, pend_d, clk_d, wrap_d;
    logic [1:0]  stb_d = 2'b00;
    logic [15:0] tune_d = 16'h0000;
    logic [31:0] step_d;

    nco_multi_clock_gen #(
        .g_num_channels(2), .g_acc_width(16), .g_tune_width(8),
        .g_base_step(16'd4096), .g_tune_limit(100), .g_dither_bits(4)
    ) u_dut_d (
        .clk_sys_i(clk), .rst_n_i(rst_d), .enable_i(en_d), .sync_i(sync_0),
        .tune_i(tune_d), .tune_stb_i(stb_d), .tune_pending_o(pend_d),
        .clk_o(clk_d), .wrap_o(wrap_d), .step_o(step_d)
    );

    // Reference model for D: LFSR, accumulators and wrap counts
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int dith(input logic [15:0] s, input int k);
        logic [15:0] r;
        r = (k == 0) ? s : {s[14:0], s[15]};
        return int'(r & 16'h000F);
    endfunction

    logic [15:0] m_lfsr;
    int m_acc0, m_acc1, m_wr0, m_wr1;

    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin
            m_lfsr <= 16'hACE1;
            m_acc0 <= 0;
            m_acc1 <= 0;
            m_wr0  <= 0;
            m_wr1  <= 0;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            if (en_d[0]) begin
                m_acc0 <= (m_acc0 + 4096 + dith(m_lfsr, 0)) % 65536;
                m_wr0  <= m_wr0 + (m_acc0 + 4096 + dith(m_lfsr, 0)) / 65536;
            end
            if (en_d[1]) begin
                m_acc1 <= (m_acc1 + 4096 + dith(m_lfsr, 1)) % 65536;
                m_wr1  <= m_wr1 + (m_acc1 + 4096 + dith(m_lfsr, 1)) / 65536;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns cycles until wrap_a[ch] is seen, or -1 on timeout
    task automatic wait_wrap_a(input int ch, input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrap_a[ch] && n < lim);
        if (!wrap_a[ch]) n = -1;
    endtask

    initial begin
        int n, h0, h1, w0, w1, mism, first;
        int last, gap, gmin, gmax, wd0, wd1;

        rst_a = 1'b0; rst_d = 1'b0;
        en_a = '0; sync_a = 1'b0; tune_a = '0; stb_a = '0;
        en_b = 1'b0; stb_b = 1'b0; tune_b = '0;
        en_c = 1'b0; stb_c = 1'b0; tune_c = '0;
        en_d = '0;

        tick();
        chk("rst_clk", clk_a, 2'b11);
        chk("rst_wrap", wrap_a, 2'b00);
        chk("rst_step", step_a, 16'h1010);
        chk("rst_pend", pend_a, 2'b00);
        rst_a = 1'b1; rst_d = 1'b1;
        tick();

        // Nominal 16-cycle period on ch0, ch1 idle
        en_a = 2'b01;
        wait_wrap_a(0, 40, n);
        chk("first_wrap", n, 16);
        wait_wrap_a(0, 40, n);
        chk("period16", n, 16);
        h0 = 0; h1 = 0; w1 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            h0 += int'(clk_a[0]);
            h1 += int'(clk_a[1]);
            w1 += int'(wrap_a[1]);
        end
        chk("high16", h0, 8);
        chk("ch1_high", h1, 16);
        chk("ch1_wrap", w1, 0);

        // Trim +16 mid-period: pending until wrap, then period 8
        ticks(4);
        tune_a[7:0] = 8'd16; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        chk("pend_set", pend_a[0], 1'b1);
        wait_wrap_a(0, 20, n);
        chk("apply_lat", n, 11);
        chk("pend_clr", pend_a[0], 1'b0);
        chk("step32", step_a[7:0], 8'd32);
        wait_wrap_a(0, 20, n);
        chk("period8", n, 8);

        // Strobe coincident with apply: +127 clamps to 128, -8 stays pending
        tune_a[7:0] = 8'h7F; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        ticks(6);
        tune_a[7:0] = 8'hF8; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        chk("coin_wrap", wrap_a[0], 1'b1);
        chk("coin_step", step_a[7:0], 8'd128);
        chk("coin_pend", pend_a[0], 1'b1);
        wait_wrap_a(0, 10, n);
        chk("period2", n, 2);
        chk("step8", step_a[7:0], 8'd8);
        chk("pend_clr2", pend_a[0], 1'b0);
        wait_wrap_a(0, 40, n);
        chk("period32", n, 32);

        // Disabled channel holds, keeps pending trim, restarts from phase 0
        en_a = 2'b00; tune_a[7:0] = 8'd16; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        chk("dis_clk", clk_a[0], 1'b1);
        chk("dis_pend", pend_a[0], 1'b1);
        h0 = 0; w0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            h0 += int'(clk_a[0]);
            w0 += int'(wrap_a[0]);
        end
        chk("dis_high", h0, 20);
        chk("dis_nowrap", w0, 0);
        chk("dis_pend2", pend_a[0], 1'b1);
        en_a = 2'b01;
        wait_wrap_a(0, 40, n);
        chk("reen_period", n, 32);
        chk("reen_step", step_a[7:0], 8'd32);

        // Return ch0 to base step, start ch1 out of phase, then sync
        tune_a[7:0] = 8'd0; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        wait_wrap_a(0, 20, n);
        chk("zero_lat", n, 7);
        chk("step_base", step_a[7:0], 8'd16);
        ticks(3);
        en_a = 2'b11;
        ticks(5);
        sync_a = 1'b1; tune_a[15:8] = 8'd0; stb_a = 2'b10;
        tick();
        sync_a = 1'b0; stb_a = 2'b00;
        chk("sync_clk", clk_a, 2'b11);
        chk("sync_wrap", wrap_a, 2'b00);
        chk("sync_pend", pend_a[1], 1'b1);
        mism = 0; first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (clk_a[0] != clk_a[1] || wrap_a[0] != wrap_a[1]) mism++;
            if (wrap_a[0] && first == 0) first = i;
        end
        chk("sync_match", mism, 0);
        chk("sync_first", first, 16);
        chk("sync_pend2", pend_a[1], 1'b0);
        ticks(7);
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        chk("sync_beats_wrap", wrap_a, 2'b00);
        chk("sync_clk2", clk_a, 2'b11);
        wait_wrap_a(0, 20, n);
        chk("post_sync", n, 16);

        // Asynchronous reset mid-run
        tune_a[7:0] = 8'd5; stb_a = 2'b01;
        tick();
        stb_a = 2'b00;
        ticks(7);
        chk("pre_rst_low", clk_a[0], 1'b0);
        #2 rst_a = 1'b0;
        #1;
        chk("mrst_clk", clk_a, 2'b11);
        chk("mrst_wrap", wrap_a, 2'b00);
        chk("mrst_pend", pend_a, 2'b00);
        chk("mrst_step", step_a, 16'h1010);
        tick();
        en_a = 2'b00;
        rst_a = 1'b1;
        tick();

        // Saturation at +-limit and lower clamp to 1
        en_b = 1'b1; tune_b = 12'h830; stb_b = 1'b1;
        en_c = 1'b1; tune_c = 12'hA1F; stb_c = 1'b1;
        tick();
        stb_b = 1'b0; stb_c = 1'b0;
        chk("b_pend", pend_b, 1'b1);
        ticks(100);
        chk("b_step_sat", step_b, 16'd500);
        chk("b_pend_clr", pend_b, 1'b0);
        chk("c_step_min", step_c, 16'd1);
        chk("c_pend_clr", pend_c, 1'b0);

        // Dither run against the reference model
        en_d = 2'b11;
        last = -1; gmin = 1000; gmax = 0; wd0 = 0; wd1 = 0;
        for (int i = 1; i <= 10000; i++) begin
            tick();
            if (wrap_d[0]) begin
                wd0++;
                if (last >= 0) begin
                    gap = i - last;
                    if (gap < gmin) gmin = gap;
                    if (gap > gmax) gmax = gap;
                end
                last = i;
            end
            if (wrap_d[1]) wd1++;
        end
        chk("d_wraps0", wd0, m_wr0);
        chk("d_wraps1", wd1, m_wr1);
        chk("d_mean", (wd0 >= 620 && wd0 <= 632), 1'b1);
        chk("d_minmax", (gmin >= 15 && gmax <= 17), 1'b1);
        #2 rst_d = 1'b0;
        #1;
        chk("d_rst_clk", clk_d, 2'b11);
        chk("d_rst_wrap", wrap_d, 2'b00);
        chk("d_rst_step", step_d, 32'h1000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
